// File: rtl/normalizer_multi_if.sv
// Handshake bundle between the core psum outputs, normalizer_multi and its consumer.
// master = environment side (cores and consumer), slave = the normalizer itself.
interface normalizer_multi_if #(
    parameter int unsigned NUM_CORE = 2,
    parameter int unsigned COL      = 8,
    parameter int unsigned BW_PSUM  = 16,
    parameter int unsigned W_OUT    = 16
);
    localparam int unsigned COL_W = $clog2(COL);

    logic [NUM_CORE-1:0]             s_valid;
    logic [NUM_CORE-1:0]             s_ready;
    logic [NUM_CORE*COL*BW_PSUM-1:0] psum;
    logic                            norm_valid;
    logic                            norm_ready;
    logic [NUM_CORE*W_OUT-1:0]       psum_norm;
    logic [COL_W-1:0]                norm_col;
    logic                            norm_last;
    logic                            div_zero;

    modport master (
        output s_valid, psum, norm_ready,
        input  s_ready, norm_valid, psum_norm, norm_col, norm_last, div_zero
    );

    modport slave (
        input  s_valid, psum, norm_ready,
        output s_ready, norm_valid, psum_norm, norm_col, norm_last, div_zero
    );
endinterface

// File: rtl/normalizer_multi.sv
// Multi-core psum normalizer: collects one vector per core, then emits (psum << FRAC_BITS) / sum
// column by column. Define NORMALIZER_ROUND_EN for round-half-up instead of truncation.
module normalizer_multi #(
    parameter int unsigned NUM_CORE  = 2,
    parameter int unsigned COL       = 8,
    parameter int unsigned BW_PSUM   = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned W_OUT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    normalizer_multi_if.slave nb
);
    localparam int unsigned BW_SUM = BW_PSUM + $clog2(NUM_CORE * COL);
    localparam int unsigned Q      = BW_PSUM + FRAC_BITS;
    localparam int unsigned QW     = Q + 1;
    localparam int unsigned COL_W  = $clog2(COL);
    localparam int unsigned CNT_W  = $clog2(Q + 1);
    localparam logic [QW-1:0] SAT_MAX = {{(QW - W_OUT){1'b0}}, {W_OUT{1'b1}}};

    typedef enum logic [1:0] {ST_COLLECT, ST_DIV, ST_OUT} state_e;

    state_e               state_q;
    logic [NUM_CORE-1:0]  full_q;
    logic [NUM_CORE-1:0]  s_ready_q;
    logic [BW_PSUM-1:0]   slot_q [NUM_CORE][COL];
    logic [BW_SUM-1:0]    sum_q;
    logic [COL_W-1:0]     col_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [Q-1:0]         dq_q   [NUM_CORE];
    logic [BW_SUM-1:0]    rem_q  [NUM_CORE];
    logic [W_OUT-1:0]     norm_q [NUM_CORE];
    logic                 norm_valid_q;
    logic                 norm_last_q;
    logic                 div_zero_q;

    logic [NUM_CORE-1:0]  take_c;
    logic [NUM_CORE-1:0]  full_d;
    logic [BW_SUM-1:0]    add_d;
    logic [Q-1:0]         dq_d   [NUM_CORE];
    logic [BW_SUM-1:0]    rem_d  [NUM_CORE];
    logic [W_OUT-1:0]     res_d  [NUM_CORE];
    logic [BW_SUM:0]      trial_c;
    logic [QW-1:0]        quo_c;
    logic [NUM_CORE*W_OUT-1:0] psum_norm_c;

    // Row sums of every vector captured on this edge; s_ready_q is zero outside COLLECT.
    always_comb begin : capture
        take_c = nb.s_valid & s_ready_q;
        full_d = full_q | take_c;
        add_d  = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            for (int i = 0; i < COL; i++) begin
                if (take_c[k]) begin
                    add_d = add_d + BW_SUM'(nb.psum[(k*COL+i)*BW_PSUM +: BW_PSUM]);
                end
            end
        end
    end

    // One restoring step per core plus the final rounding/saturation of that step's result.
    always_comb begin : div_step
        trial_c = '0;
        quo_c   = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            trial_c = {rem_q[k], dq_q[k][Q-1]};
            if (trial_c >= {1'b0, sum_q}) begin
                rem_d[k] = BW_SUM'(trial_c - {1'b0, sum_q});
                dq_d[k]  = {dq_q[k][Q-2:0], 1'b1};
            end else begin
                rem_d[k] = BW_SUM'(trial_c);
                dq_d[k]  = {dq_q[k][Q-2:0], 1'b0};
            end
            quo_c = {1'b0, dq_d[k]};
`ifdef NORMALIZER_ROUND_EN
            if ({rem_d[k], 1'b0} >= {1'b0, sum_q}) begin
                quo_c = quo_c + QW'(1);
            end
`endif
            // A zero divisor would yield all ones; the defined result is zero.
            if (sum_q == '0) begin
                quo_c = '0;
            end
            res_d[k] = (quo_c > SAT_MAX) ? {W_OUT{1'b1}} : W_OUT'(quo_c);
        end
    end

    always_ff @(posedge clk) begin : fsm
        if (reset) begin
            state_q      <= ST_COLLECT;
            full_q       <= '0;
            s_ready_q    <= '1;
            sum_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            norm_valid_q <= 1'b0;
            norm_last_q  <= 1'b0;
            div_zero_q   <= 1'b0;
            for (int k = 0; k < NUM_CORE; k++) begin
                dq_q[k]   <= '0;
                rem_q[k]  <= '0;
                norm_q[k] <= '0;
                for (int i = 0; i < COL; i++) begin
                    slot_q[k][i] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    for (int k = 0; k < NUM_CORE; k++) begin
                        for (int i = 0; i < COL; i++) begin
                            if (take_c[k]) begin
                                slot_q[k][i] <= nb.psum[(k*COL+i)*BW_PSUM +: BW_PSUM];
                            end
                        end
                    end
                    full_q <= full_d;
                    sum_q  <= sum_q + add_d;
                    if (&full_d) begin
                        state_q   <= ST_DIV;
                        col_q     <= '0;
                        cnt_q     <= '0;
                        s_ready_q <= '0;
                    end else begin
                        s_ready_q <= ~full_d;
                    end
                end
                ST_DIV: begin
                    // cnt 0 loads the column, cnt 1..Q are the Q quotient steps.
                    if (cnt_q == '0) begin
                        for (int k = 0; k < NUM_CORE; k++) begin
                            dq_q[k]  <= {slot_q[k][col_q], {FRAC_BITS{1'b0}}};
                            rem_q[k] <= '0;
                        end
                    end else begin
                        dq_q  <= dq_d;
                        rem_q <= rem_d;
                    end
                    if (cnt_q == CNT_W'(Q)) begin
                        state_q      <= ST_OUT;
                        cnt_q        <= '0;
                        norm_q       <= res_d;
                        norm_valid_q <= 1'b1;
                        norm_last_q  <= (col_q == COL_W'(COL - 1));
                        div_zero_q   <= (sum_q == '0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (nb.norm_ready) begin
                        norm_valid_q <= 1'b0;
                        if (col_q != COL_W'(COL - 1)) begin
                            col_q   <= col_q + COL_W'(1);
                            state_q <= ST_DIV;
                        end else begin
                            state_q     <= ST_COLLECT;
                            col_q       <= '0;
                            full_q      <= '0;
                            sum_q       <= '0;
                            s_ready_q   <= '1;
                            norm_last_q <= 1'b0;
                            div_zero_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    always_comb begin : pack_out
        psum_norm_c = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            psum_norm_c[k*W_OUT +: W_OUT] = norm_q[k];
        end
    end

    assign nb.s_ready    = s_ready_q;
    assign nb.norm_valid = norm_valid_q;
    assign nb.psum_norm  = psum_norm_c;
    assign nb.norm_col   = col_q;
    assign nb.norm_last  = norm_last_q;
    assign nb.div_zero   = div_zero_q;
endmodule

// File: tb/tb_normalizer_multi.sv
// Directed bench for normalizer_multi: arithmetic model + per-beat compare, plus literal pins.
module tb_normalizer_multi;
    localparam int FRAC = 8;

    typedef logic [15:0] vec_t [2][8];
    typedef struct {
        int          col;
        bit          last;
        bit          dz;
        logic [31:0] norm;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    beat_t       exp_q [$];
    logic [31:0] seen  [8];
    vec_t        vin;
    vec_t        tmp;

    normalizer_multi_if #(.NUM_CORE(2), .COL(8), .BW_PSUM(16), .W_OUT(16)) bus ();
    normalizer_multi_if #(.NUM_CORE(2), .COL(8), .BW_PSUM(16), .W_OUT(8))  bus8 ();

    normalizer_multi #(.NUM_CORE(2), .COL(8), .BW_PSUM(16), .FRAC_BITS(8), .W_OUT(16)) dut (
        .clk(clk), .reset(reset), .nb(bus.slave));
    normalizer_multi #(.NUM_CORE(2), .COL(8), .BW_PSUM(16), .FRAC_BITS(8), .W_OUT(8)) dut8 (
        .clk(clk), .reset(reset), .nb(bus8.slave));

    always #5 clk = ~clk;

    function automatic longint unsigned model_q(input longint unsigned p, input longint unsigned s,
                                                input int wout);
        longint unsigned q;
        longint unsigned mx;
        if (s == 0) return 0;
        q = (p << FRAC) / s;
`ifdef NORMALIZER_ROUND_EN
        if (2 * ((p << FRAC) % s) >= s) q++;
`endif
        mx = (64'd1 << wout) - 1;
        return (q > mx) ? mx : q;
    endfunction

    function automatic logic [255:0] pack(input vec_t v);
        logic [255:0] r = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                r[(k*8+i)*16 +: 16] = v[k][i];
        return r;
    endfunction

    task automatic push_model(input vec_t v);
        longint unsigned s = 0;
        beat_t b;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                s += longint'(v[k][i]);
        for (int c = 0; c < 8; c++) begin
            b.col  = c;
            b.last = (c == 7);
            b.dz   = (s == 0);
            b.norm = {16'(model_q(v[1][c], s, 16)), 16'(model_q(v[0][c], s, 16))};
            exp_q.push_back(b);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_beats_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_col(input string name, input int c);
        int n = 0;
        while (!(bus.norm_valid && int'(bus.norm_col) == c) && n < 500) begin
            tick();
            n++;
        end
        check({name, "_reached_col"}, (n < 500) ? 1 : 0, 1);
    endtask

    // Every beat on the main DUT is checked against the head of the model queue.
    always @(negedge clk) begin
        if (!reset && bus.norm_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got col=%0d norm=%h, want no beat", bus.norm_col,
                         bus.psum_norm);
            end else begin
                if (bus.psum_norm !== exp_q[0].norm || int'(bus.norm_col) != exp_q[0].col ||
                    bus.norm_last !== exp_q[0].last || bus.div_zero !== exp_q[0].dz) begin
                    errors++;
                    $display("FAIL beat: got norm=%h col=%0d last=%b dz=%b, want norm=%h col=%0d last=%b dz=%b",
                             bus.psum_norm, bus.norm_col, bus.norm_last, bus.div_zero,
                             exp_q[0].norm, exp_q[0].col, exp_q[0].last, exp_q[0].dz);
                end
                if (bus.norm_ready) begin
                    seen[exp_q[0].col] = bus.psum_norm;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int t0;
        int n;
        logic [31:0] held;
        reset           = 1'b1;
        bus.s_valid     = '0;
        bus.psum        = '0;
        bus.norm_ready  = 1'b1;
        bus8.s_valid    = '0;
        bus8.psum       = '0;
        bus8.norm_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_s_ready", bus.s_ready, 3);
        check("rst_norm_valid", bus.norm_valid, 0);
        check("rst_psum_norm", bus.psum_norm, 0);
        check("rst_norm_col", bus.norm_col, 0);
        check("rst_norm_last", bus.norm_last, 0);
        check("rst_div_zero", bus.div_zero, 0);

        // Basic: both cores i, sum 56, latency Q+1 and Q+1 after each handshake.
        for (int i = 0; i < 8; i++) begin vin[0][i] = 16'(i); vin[1][i] = 16'(i); end
        push_model(vin);
        bus.psum = pack(vin); bus.s_valid = 2'b11;
        tick();
        bus.s_valid = 2'b00;
        check("basic_s_ready_busy", bus.s_ready, 0);
        n = 0;
        while (!bus.norm_valid && n < 100) begin tick(); n++; end
        check("basic_first_latency", n, 25);
        n = 0;
        do begin tick(); n++; end while (!(bus.norm_valid && bus.norm_col == 3'd1) && n < 100);
        check("basic_next_latency", n, 26);
        drain("basic");
`ifdef NORMALIZER_ROUND_EN
        check("basic_col3", seen[3], {16'd14, 16'd14});
`else
        check("basic_col3", seen[3], {16'd13, 16'd13});
`endif
        check("basic_col7", seen[7], {16'd32, 16'd32});
        check("basic_s_ready_after", bus.s_ready, 3);

        // Backpressure at col2 for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            vin[0][i] = 16'(10 * i + 5);
            vin[1][i] = 16'(200 - 7 * i);
        end
        push_model(vin);
        bus.psum = pack(vin); bus.s_valid = 2'b11;
        tick();
        bus.s_valid = 2'b00;
        wait_col("bp", 2);
        bus.norm_ready = 1'b0;
        held = bus.psum_norm;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", bus.norm_valid, 1);
            check("bp_hold_col", bus.norm_col, 2);
            check("bp_hold_norm", bus.psum_norm, held);
        end
        bus.norm_ready = 1'b1;
        drain("bp");

        // Staggered arrival; the second core1 vector must be ignored.
        for (int i = 0; i < 8; i++) begin
            vin[0][i] = 16'(3000 + 100 * i);
            vin[1][i] = 16'(17 * i + 1);
            tmp[0][i] = 16'(0);
            tmp[1][i] = 16'(60000);
        end
        t0 = cyc;
        while (cyc < t0 + 2) tick();
        bus.psum = pack(vin); bus.s_valid = 2'b10;
        tick();
        bus.s_valid = 2'b00;
        while (cyc < t0 + 7) tick();
        check("stag_s_ready_c8", bus.s_ready, 1);
        bus.psum = pack(tmp); bus.s_valid = 2'b10;
        tick();
        bus.s_valid = 2'b00;
        while (cyc < t0 + 14) tick();
        bus.psum = pack(vin); bus.s_valid = 2'b01;
        push_model(vin);
        tick();
        bus.s_valid = 2'b00;
        while (!bus.norm_valid && cyc < t0 + 200) tick();
        check("stag_first_valid_cycle", cyc - t0, 40);
        drain("stag");

        // Zero sum.
        for (int i = 0; i < 8; i++) begin vin[0][i] = '0; vin[1][i] = '0; end
        push_model(vin);
        bus.psum = pack(vin); bus.s_valid = 2'b11;
        tick();
        bus.s_valid = 2'b00;
        drain("zero");
        check("zero_col5_norm", seen[5], 0);

        // Reset during DIV of col4, then a clean transaction.
        for (int i = 0; i < 8; i++) begin
            vin[0][i] = 16'(1000 + i);
            vin[1][i] = 16'(50 * i);
        end
        push_model(vin);
        bus.psum = pack(vin); bus.s_valid = 2'b11;
        tick();
        bus.s_valid = 2'b00;
        wait_col("rst", 3);
        repeat (6) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("rst_mid_s_ready", bus.s_ready, 3);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.norm_valid) n++;
            tick();
        end
        check("rst_mid_no_valid", n, 0);
        for (int i = 0; i < 8; i++) begin
            vin[0][i] = 16'(65535 - 1000 * i);
            vin[1][i] = 16'(123 * i);
        end
        push_model(vin);
        bus.psum = pack(vin); bus.s_valid = 2'b11;
        tick();
        bus.s_valid = 2'b00;
        drain("post_rst");

        // Saturation on the 8-bit output instance: 100*256/100 = 256 -> 255.
        for (int i = 0; i < 8; i++) begin vin[0][i] = '0; vin[1][i] = '0; end
        vin[0][0] = 16'd100;
        bus8.psum = pack(vin); bus8.s_valid = 2'b11;
        tick();
        bus8.s_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            n = 0;
            while (!bus8.norm_valid && n < 100) begin tick(); n++; end
            check("sat_valid_seen", (n < 100) ? 1 : 0, 1);
            check("sat_col", bus8.norm_col, c);
            check("sat_norm", bus8.psum_norm, (c == 0) ? 16'h00FF : 16'h0000);
            check("sat_div_zero", bus8.div_zero, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
